autocorr_inverter: RTL

Recovers every N-bit binary sequence whose autocorrelation equals a supplied lag vector. The vector uses the same symmetric, 2N-1-element format our autocorrelator produces, so this block is the inverse path of that block. It searches all 2^N candidates exhaustively, one per clock. Each match is reported with a valid pulse, and a done/count summary is issued at the end. It sits downstream of the correlator output bus and checks or decodes correlator results in the demo design.

---
 rtl/autocorr_inverter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/autocorr_inverter.sv
// autocorr_inverter: exhaustive inverse of the symmetric autocorrelator.
// Walks all 2^N candidate sequences, one per clock, and reports each one
// whose lag vector equals the latched acorr_in, followed by a done/count
// summary. Asymmetric input vectors are rejected before any search.
module autocorr_inverter #(
    parameter  int N = 3,
    localparam int W = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [(2*N-1)*W-1:0] acorr_in,
    output logic                 busy,
    output logic                 match_valid,
    output logic [N-1:0]         match_seq,
    output logic                 done,
    output logic [N:0]           match_count,
    output logic                 err
);

    localparam int L = 2 * N - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [L*W-1:0]   r_vec;
    logic [N-1:0]     r_cand;
    logic             r_mv;
    logic [N-1:0]     r_seq;
    logic [N:0]       r_count;
    logic             r_err;

    logic [W-1:0]     w_lag [N];
    logic             w_asym;
    logic             w_match;
    logic             w_last;

    assign match_valid = r_mv;
    assign match_seq   = r_seq;
    assign match_count = r_count;
    assign err         = r_err;
    assign w_last      = &r_cand;

    // Lags 0..N-1 of the current candidate; the upper half mirrors these
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            w_lag[i] = '0;
            for (int unsigned y = 0; y <= i; y++) begin
                w_lag[i] = w_lag[i] + W'(r_cand[y] & r_cand[N-1-i+y]);
            end
        end
    end

    // Candidate matches when every element of the latched vector equals its lag
    always_comb begin
        int unsigned j;
        w_match = 1'b1;
        for (int unsigned i = 0; i < L; i++) begin
            j = (i < N) ? i : (L - 1 - i);
            if (r_vec[i*W +: W] != w_lag[j]) begin
                w_match = 1'b0;
            end
        end
    end

    // Latched vector is asymmetric when any element differs from its mirror
    always_comb begin
        w_asym = 1'b0;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (r_vec[i*W +: W] != r_vec[(L-1-i)*W +: W]) begin
                w_asym = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the state-decoded busy/done outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_asym ? S_DONE : S_SEARCH;
            end
            S_SEARCH: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: vector latch, candidate counter, match reporting and summary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec   <= '0;
            r_cand  <= '0;
            r_mv    <= 1'b0;
            r_seq   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_mv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec   <= acorr_in;
                        r_cand  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_asym) begin
                        r_err <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (w_match) begin
                        r_mv    <= 1'b1;
                        r_seq   <= r_cand;
                        r_count <= r_count + (N+1)'(1);
                    end
                    // Counter parks on the last candidate instead of wrapping
                    if (!w_last) begin
                        r_cand <= r_cand + N'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
